// File: rtl/ysyx_23060201_ifu_hs.sv
// Instruction fetch unit: one-outstanding memory request handshake feeding a small instruction FIFO.
// Optional feature: define IFU_ACCESS_FAULT_EN to record access faults and halt fetch until a redirect.
module ysyx_23060201_ifu_hs #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] dnpc,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  rsp_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic                  out_fault
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP,
        S_HALT
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   fetch_pc;

    logic [ADDR_WIDTH-1:0]   fifo_pc   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fifo_inst [FIFO_DEPTH];
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [CNT_W-1:0]        count;

    logic                    fifo_full;
    logic                    push;
    logic                    pop;
    logic                    rsp_fault;

    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));

    // Requests are masked while rst is high because the async-reset state alone would already read S_REQ.
    assign req_valid = !rst && (state == S_REQ) && !fifo_full && !jump_en;
    assign req_addr  = fetch_pc;

    // A response arriving together with a redirect belongs to the old path and is never pushed.
    assign push      = (state == S_WAIT) && rsp_valid && !jump_en;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    assign out_pc    = out_valid ? fifo_pc[head]   : '0;
    assign out_inst  = out_valid ? fifo_inst[head] : '0;

`ifdef IFU_ACCESS_FAULT_EN
    logic fifo_fault [FIFO_DEPTH];

    assign rsp_fault = rsp_err;
    assign out_fault = out_valid && fifo_fault[head];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_fault[tail] <= rsp_fault;
        end
    end
`else
    logic unused_rsp_err;

    assign unused_rsp_err = rsp_err;
    assign rsp_fault      = 1'b0;
    assign out_fault      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (!jump_en && req_valid && req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_valid) begin
                    state_nxt = (!jump_en && rsp_fault) ? S_HALT : S_REQ;
                end else if (jump_en) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                // The stale beat is swallowed; a further redirect here only retargets fetch_pc.
                if (rsp_valid) begin
                    state_nxt = S_REQ;
                end
            end
            S_HALT: begin
                if (jump_en) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (jump_en) begin
            fetch_pc <= dnpc;
        end else if (push) begin
            fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (jump_en) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; entries are only observed through out_valid, which is reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[tail]   <= fetch_pc;
            fifo_inst[tail] <= rsp_data;
        end
    end

endmodule

// File: tb/tb_ysyx_23060201_ifu_hs.sv
// Randomized bench for ysyx_23060201_ifu_hs: a transaction-level model (expected instruction queue,
// outstanding/stale flags) plus a one-request memory responder; honours IFU_ACCESS_FAULT_EN if defined.
module tb_ysyx_23060201_ifu_hs;

    localparam int          AW       = 32;
    localparam int          DW       = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RST_PC   = 32'h8000_0000;
`ifdef IFU_ACCESS_FAULT_EN
    localparam bit          FAULT_EN = 1'b1;
`else
    localparam bit          FAULT_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          jump_en;
    logic [AW-1:0] dnpc;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_pc;
    logic [DW-1:0] out_inst;
    logic          out_fault;

    ysyx_23060201_ifu_hs #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .jump_en   (jump_en),
        .dnpc      (dnpc),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_fault (out_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] inst;
        logic          fault;
    } entry_t;

    // Model: instructions the decoder should see, in order, plus fetch bookkeeping.
    entry_t        exp_q[$];
    logic [AW-1:0] m_pc;
    bit            m_stale;
    bit            m_halt;
    // Memory responder: at most one request in flight.
    bit            mem_busy;
    int            mem_lat;
    logic [AW-1:0] mem_addr;

    int n_checks;
    int n_fail;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc     = RST_PC;
        m_stale  = 1'b0;
        m_halt   = 1'b0;
        mem_busy = 1'b0;
        mem_lat  = 0;
    endtask

    // One clock cycle: drive at the falling edge, compare 1 ns later, then advance the model
    // to what the following rising edge must produce.
    task automatic cycle(input int p_jump, input int p_rr, input int p_or, input int lat_max,
                         input bit hold_rst);
        bit     rv;
        bit     exp_req;
        bit     fire;
        bit     pop;
        entry_t e;

        @(negedge clk);
        rst       = hold_rst;
        jump_en   = ($urandom_range(99) < p_jump);
        dnpc      = RST_PC + ($urandom_range(63) << 2);
        req_ready = ($urandom_range(99) < p_rr);
        out_ready = ($urandom_range(99) < p_or);
        rv        = !hold_rst && mem_busy && (mem_lat == 0);
        rsp_valid = rv;
        rsp_data  = rv ? mem_word(mem_addr) : $urandom;
        rsp_err   = rv ? ($urandom_range(7) == 0) : 1'($urandom_range(1));
        #1;

        if (hold_rst) begin
            model_reset();
            check("rst_req_valid", req_valid, 1'b0);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_out_pc",    out_pc,    '0);
            check("rst_out_inst",  out_inst,  '0);
            check("rst_out_fault", out_fault, 1'b0);
            return;
        end

        exp_req = !mem_busy && !m_halt && (exp_q.size() < DEPTH) && !jump_en;
        check("req_valid", req_valid, exp_req);
        if (exp_req) begin
            check("req_addr", req_addr, m_pc);
        end
        check("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("out_pc",    out_pc,    exp_q[0].pc);
            check("out_inst",  out_inst,  exp_q[0].inst);
            check("out_fault", out_fault, exp_q[0].fault);
        end

        fire = exp_req && req_ready;
        pop  = (exp_q.size() != 0) && out_ready;

        if (jump_en) begin
            exp_q.delete();
            m_pc    = dnpc;
            m_halt  = 1'b0;
            m_stale = mem_busy && !rv;
        end else begin
            if (pop) begin
                void'(exp_q.pop_front());
            end
            if (rv) begin
                if (!m_stale) begin
                    e.pc    = m_pc;
                    e.inst  = rsp_data;
                    e.fault = FAULT_EN && rsp_err;
                    exp_q.push_back(e);
                    m_pc = m_pc + 32'd4;
                    if (FAULT_EN && rsp_err) begin
                        m_halt = 1'b1;
                    end
                end
                m_stale = 1'b0;
            end
        end

        if (rv) begin
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            mem_lat--;
        end
        if (fire) begin
            mem_busy = 1'b1;
            mem_addr = m_pc;
            mem_lat  = $urandom_range(lat_max);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        jump_en   = 1'b0;
        dnpc      = '0;
        req_ready = 1'b0;
        out_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        model_reset();

        repeat (3) cycle(0, 100, 0, 0, 1'b1);

        // Reset release, always-ready memory with single-cycle latency, decoder stalled until full.
        repeat (12) cycle(0, 100, 0, 0, 1'b0);
        // Drain one at a time, then free-running.
        repeat (6)  cycle(0, 100, 50, 0, 1'b0);
        repeat (10) cycle(0, 100, 100, 0, 1'b0);

        // Mid-transaction reset with slow memory.
        repeat (2) cycle(0, 100, 0, 3, 1'b0);
        cycle(0, 100, 0, 3, 1'b1);
        repeat (8) cycle(0, 100, 100, 0, 1'b0);

        // Randomized mixes: redirect-heavy, backpressure-heavy, slow memory, occasional reset.
        for (int phase = 0; phase < 4; phase++) begin
            for (int n = 0; n < 800; n++) begin
                case (phase)
                    0:       cycle(15, 80, 70, 1, ($urandom_range(299) == 0));
                    1:       cycle(5,  50, 20, 3, ($urandom_range(299) == 0));
                    2:       cycle(25, 100, 90, 3, ($urandom_range(299) == 0));
                    default: cycle(8,  70, 50, 2, ($urandom_range(299) == 0));
                endcase
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060201_ifu_hs.md
YSYX_23060201_IFU_HS -- requirements
Module: ysyx_23060201_ifu_hs

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning PC and memory-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning instruction word width.
REQ-003 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning fetch start address after reset.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2, meaning fetched-instruction buffer entries; power of two, at least 2.
REQ-005 SHALL have the following ports; one clock `clk`; reset `rst` is asynchronous and active-high.
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- jump_en  in  1  redirect request.
- dnpc  in  ADDR_WIDTH  redirect target.
- req_valid  out  1  memory read request valid.
- req_ready  in  1  memory accepts request.
- req_addr  out  ADDR_WIDTH  request address (current fetch PC).
- rsp_valid  in  1  read data valid, one cycle per accepted request.
- rsp_data  in  DATA_WIDTH  read data.
- rsp_err  in  1  access fault for this response.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts instruction.
- out_pc  out  ADDR_WIDTH  PC of the head instruction.
- out_inst  out  DATA_WIDTH  head instruction.
- out_fault  out  1  head entry faulted.

Function
REQ-006 SHALL implement FSM states S_REQ, S_WAIT, S_DROP, S_HALT.
REQ-007 SHALL keep at most one outstanding memory request.
REQ-008 In S_REQ: req_valid = (FIFO count < FIFO_DEPTH) and not jump_en; req_addr = fetch_pc.
REQ-009 On req_valid & req_ready: move to S_WAIT.
REQ-010 In S_WAIT, on rsp_valid: push {fetch_pc, rsp_data, rsp_err} into FIFO; fetch_pc <= fetch_pc + 4 (mod 2^ADDR_WIDTH); return to S_REQ.
- Next request is therefore issued no earlier than the cycle after the response.
REQ-011 Pushed entry SHALL appear on out_* the cycle after push; there is no response-to-output bypass.
REQ-012 out_valid = FIFO not empty; out_pc, out_inst and out_fault show the head entry.
- Head is popped on out_valid & out_ready.
- Push and pop in the same cycle are both honoured; count is unchanged.
REQ-013 Redirect on jump_en in any state:
- FIFO cleared at the next edge; an out handshake in the same cycle still counts as consumed.
- fetch_pc <= dnpc.
REQ-014 Redirect state transitions:
- From S_WAIT without rsp_valid: go to S_DROP.
- From S_WAIT with rsp_valid: the response is discarded and the FSM goes to S_REQ.
- From S_REQ or S_HALT: go to S_REQ.
REQ-015 S_DROP SHALL discard the next rsp_valid beat without pushing, then go to S_REQ.
- A further jump_en while in S_DROP only updates fetch_pc.
REQ-016 FIFO pointers SHALL wrap modulo FIFO_DEPTH; a full FIFO suppresses req_valid, with no overflow or underflow.

Reset
REQ-017 On rst (asynchronous), the block SHALL reset as follows:
- state = S_REQ, fetch_pc = RESET_PC, FIFO empty.
- Resulting outputs: out_valid = 0, out_fault = 0, out_pc and out_inst = 0, req_valid = 0 while rst is high.
- Any in-flight request is abandoned; responses while rst is high are ignored.
REQ-018 The first request (req_addr = RESET_PC) SHALL be issued in the first cycle after rst deasserts.

Configuration
REQ-019 Macro IFU_ACCESS_FAULT_EN, when defined:
- A response with rsp_err = 1 is pushed with fault = 1.
- The FSM enters S_HALT and issues no requests until jump_en.
REQ-020 Macro IFU_ACCESS_FAULT_EN, when undefined:
- rsp_err is ignored and out_fault is tied to 0.
- S_HALT is unreachable and is not synthesised.

Verification
REQ-021 Reset release with req_ready = 1 and 1-cycle response latency -> requests at 0x80000000 and 0x80000004; out_valid rises 2 cycles after each request is accepted.
REQ-022 out_ready = 0 with FIFO_DEPTH = 2 -> exactly 2 entries buffered, req_valid stays 0; one pop -> exactly one new request.
REQ-023 jump_en with dnpc = 0x80000100 while in S_WAIT, response 3 cycles later -> that response is dropped, the next req_addr is 0x80000100, and no stale out_valid appears.
REQ-024 rsp_valid and jump_en in the same cycle -> no push; FIFO empty; next req_addr = dnpc.
REQ-025 With IFU_ACCESS_FAULT_EN, rsp_err = 1 at 0x80000008 -> out_fault = 1 with out_pc = 0x80000008, no further requests until jump_en; without the macro, out_fault = 0 and fetch continues to 0x8000000C.
REQ-026 rst asserted mid-S_WAIT -> out_valid = 0 and req_valid = 0 immediately; after release, req_addr = RESET_PC.
